// File: rtl/clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl
// Mode/adjust controller for the 24-hour clock counter chain. Debounces the
// mode and increment buttons, walks RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN
// and drives the counter enable / increment / clear strobes plus display blink
// blanking.
//
// Ports
//   CP          in   system clock, all logic on posedge
//   reset       in   asynchronous active-low reset
//   tick_1hz    in   one-cycle pulse at 1 Hz (RUN timebase, SET timeout)
//   tick_2hz    in   one-cycle pulse at 2 Hz (blink, auto-repeat)
//   key_mode    in   raw mode button, active-high, asynchronous
//   key_inc     in   raw increment button, active-high, asynchronous
//   sec_en      out  seconds count enable, one cycle per tick_1hz in RUN
//   hour_incre  out  one-cycle hour increment request
//   min_incre   out  one-cycle minute increment request
//   sec_clr_n   out  one-cycle active-low seconds clear
//   mode        out  00 RUN, 01 SET_HOUR, 10 SET_MIN, 11 SET_SEC
//   blank_hour  out  blank hour digits while high
//   blank_min   out  blank minute digits while high
// -----------------------------------------------------------------------------
module clock_set_ctrl #(
  parameter int DEB_CYCLES    = 16,
  parameter int RPT_TICKS     = 3,
  parameter int TIMEOUT_TICKS = 10
) (
  input  logic       CP,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       key_mode,
  input  logic       key_inc,
  output logic       sec_en,
  output logic       hour_incre,
  output logic       min_incre,
  output logic       sec_clr_n,
  output logic [1:0] mode,
  output logic       blank_hour,
  output logic       blank_min
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int RW = $clog2(RPT_TICKS + 1);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(RPT_TICKS - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_TICKS - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_SET_HOUR = 2'b01,
    ST_SET_MIN  = 2'b10,
    ST_SET_SEC  = 2'b11
  } state_t;

  // Bit 0 carries the mode key, bit 1 the increment key.
  logic [1:0]    key_raw_s;
  logic [1:0]    sync1_r, sync2_r, deb_r, deb_dly_r;
  logic [DW-1:0] deb_cnt_r [2];
  logic [RW-1:0] rpt_cnt_r;
  logic [TW-1:0] to_cnt_r;
  logic          blink_phase_r;
  state_t        state_r, state_nxt_s;

  logic mode_press_s, inc_press_s, in_set_s, rpt_zone_s;
  logic timeout_s, rpt_fire_s, mode_acc_s, inc_acc_s;
  logic sec_en_r, hour_incre_r, min_incre_r, sec_clr_n_r;
  logic blank_hour_r, blank_min_r;

  assign key_raw_s = {key_inc, key_mode};

  // Two-flop synchronizer for both raw buttons.
  always_ff @(posedge CP or negedge reset) begin
    if (!reset) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
    end else begin
      sync1_r <= key_raw_s;
      sync2_r <= sync1_r;
    end
  end

  // Debouncer: accept a new level only after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge CP or negedge reset) begin
    if (!reset) begin
      deb_r     <= 2'b00;
      deb_dly_r <= 2'b00;
      for (int i = 0; i < 2; i++) deb_cnt_r[i] <= '0;
    end else begin
      deb_dly_r <= deb_r;
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] != deb_r[i]) begin
          if (deb_cnt_r[i] == DEB_LAST) begin
            deb_r[i]     <= sync2_r[i];
            deb_cnt_r[i] <= '0;
          end else begin
            deb_cnt_r[i] <= deb_cnt_r[i] + 1'b1;
          end
        end else begin
          deb_cnt_r[i] <= '0;
        end
      end
    end
  end

  // Press qualification and next-state decode. Timeout outranks everything,
  // then a mode press outranks an increment in the same cycle.
  always_comb begin
    mode_press_s = deb_r[0] & ~deb_dly_r[0];
    inc_press_s  = deb_r[1] & ~deb_dly_r[1];
    in_set_s     = (state_r != ST_RUN);
    rpt_zone_s   = (state_r == ST_SET_HOUR) || (state_r == ST_SET_MIN);
    timeout_s    = in_set_s & tick_1hz & (to_cnt_r == TO_LAST);
    rpt_fire_s   = rpt_zone_s & deb_r[1] & tick_2hz & (rpt_cnt_r == RPT_LAST);
    mode_acc_s   = mode_press_s & ~timeout_s;
    inc_acc_s    = in_set_s & ~mode_press_s & ~timeout_s & (inc_press_s | rpt_fire_s);
    state_nxt_s  = state_r;
    if (timeout_s) begin
      state_nxt_s = ST_RUN;
    end else if (mode_acc_s) begin
      case (state_r)
        ST_RUN:      state_nxt_s = ST_SET_HOUR;
        ST_SET_HOUR: state_nxt_s = ST_SET_MIN;
        ST_SET_MIN:  state_nxt_s = ST_SET_SEC;
        ST_SET_SEC:  state_nxt_s = ST_RUN;
        default:     state_nxt_s = ST_RUN;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Mode state register.
  always_ff @(posedge CP or negedge reset) begin
    if (!reset) state_r <= ST_RUN;
    else        state_r <= state_nxt_s;
  end

  // Auto-repeat hold counter; saturates at the last pre-repeat value so each
  // further tick_2hz fires while held.
  always_ff @(posedge CP or negedge reset) begin
    if (!reset) begin
      rpt_cnt_r <= '0;
    end else if (!rpt_zone_s || !deb_r[1] || mode_press_s || timeout_s) begin
      rpt_cnt_r <= '0;
    end else if (tick_2hz && (rpt_cnt_r != RPT_LAST)) begin
      rpt_cnt_r <= rpt_cnt_r + 1'b1;
    end else begin
      rpt_cnt_r <= rpt_cnt_r;
    end
  end

  // Inactivity timeout counter, restarted by every accepted press.
  always_ff @(posedge CP or negedge reset) begin
    if (!reset) begin
      to_cnt_r <= '0;
    end else if (!in_set_s || mode_acc_s || inc_acc_s || timeout_s) begin
      to_cnt_r <= '0;
    end else if (tick_1hz) begin
      to_cnt_r <= to_cnt_r + 1'b1;
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end

  // Registered strobes and blink blanking.
  always_ff @(posedge CP or negedge reset) begin
    if (!reset) begin
      sec_en_r      <= 1'b0;
      hour_incre_r  <= 1'b0;
      min_incre_r   <= 1'b0;
      sec_clr_n_r   <= 1'b1;
      blink_phase_r <= 1'b0;
      blank_hour_r  <= 1'b0;
      blank_min_r   <= 1'b0;
    end else begin
      sec_en_r      <= (state_r == ST_RUN) & tick_1hz;
      hour_incre_r  <= inc_acc_s & (state_r == ST_SET_HOUR);
      min_incre_r   <= inc_acc_s & (state_r == ST_SET_MIN);
      sec_clr_n_r   <= ~(inc_acc_s & (state_r == ST_SET_SEC));
      blink_phase_r <= blink_phase_r ^ tick_2hz;
      // Digits stay lit while the increment key is held.
      blank_hour_r  <= (state_r == ST_SET_HOUR) & blink_phase_r & ~deb_r[1];
      blank_min_r   <= (state_r == ST_SET_MIN) & blink_phase_r & ~deb_r[1];
    end
  end

  assign sec_en     = sec_en_r;
  assign hour_incre = hour_incre_r;
  assign min_incre  = min_incre_r;
  assign sec_clr_n  = sec_clr_n_r;
  assign mode       = state_r;
  assign blank_hour = blank_hour_r;
  assign blank_min  = blank_min_r;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_set_ctrl
// Directed self-checking bench for clock_set_ctrl with DEB_CYCLES=4.
// -----------------------------------------------------------------------------
module tb_clock_set_ctrl;

  logic       CP, reset, tick_1hz, tick_2hz, key_mode, key_inc;
  logic       sec_en, hour_incre, min_incre, sec_clr_n, blank_hour, blank_min;
  logic [1:0] mode;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Monotonic event totals collected on the falling edge.
  int n_sec_en = 0, n_hour = 0, n_min = 0, n_clr = 0, n_mode_chg = 0, n_multi = 0;
  logic [1:0] mode_prev = 2'b00;

  clock_set_ctrl #(.DEB_CYCLES(4), .RPT_TICKS(3), .TIMEOUT_TICKS(10)) dut (
    .CP(CP), .reset(reset), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .key_mode(key_mode), .key_inc(key_inc), .sec_en(sec_en),
    .hour_incre(hour_incre), .min_incre(min_incre), .sec_clr_n(sec_clr_n),
    .mode(mode), .blank_hour(blank_hour), .blank_min(blank_min)
  );

  initial begin
    CP = 1'b0;
    forever #5 CP = ~CP;
  end

  always @(negedge CP) begin
    if (sec_en === 1'b1) n_sec_en <= n_sec_en + 1;
    if (hour_incre === 1'b1) n_hour <= n_hour + 1;
    if (min_incre === 1'b1) n_min <= n_min + 1;
    if (sec_clr_n === 1'b0) n_clr <= n_clr + 1;
    if (mode !== mode_prev) n_mode_chg <= n_mode_chg + 1;
    if ((32'(hour_incre === 1'b1) + 32'(min_incre === 1'b1) + 32'(sec_clr_n === 1'b0)) > 32'd1)
      n_multi <= n_multi + 1;
    mode_prev <= mode;
  end

  task automatic step();
    @(posedge CP);
    #1;
  endtask

  task automatic check(input string name, input int actual, input int expected);
    chk_cnt++;
    if (actual !== expected) $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    else pass_cnt++;
  endtask

  task automatic pulse_1hz();
    tick_1hz = 1'b1; step(); tick_1hz = 1'b0; repeat (3) step();
  endtask

  task automatic pulse_2hz();
    tick_2hz = 1'b1; step(); tick_2hz = 1'b0; repeat (3) step();
  endtask

  task automatic press_mode();
    key_mode = 1'b1; repeat (10) step(); key_mode = 1'b0; repeat (10) step();
  endtask

  task automatic press_inc();
    key_inc = 1'b1; repeat (10) step(); key_inc = 1'b0; repeat (10) step();
  endtask

  task automatic test_reset();
    reset = 1'b0; tick_1hz = 1'b0; tick_2hz = 1'b0; key_mode = 1'b0; key_inc = 1'b0;
    repeat (3) step();
    check("reset_mode", int'(mode), 0);
    check("reset_sec_en", int'(sec_en), 0);
    check("reset_hour_incre", int'(hour_incre), 0);
    check("reset_min_incre", int'(min_incre), 0);
    check("reset_sec_clr_n", int'(sec_clr_n), 1);
    check("reset_blank", int'({blank_hour, blank_min}), 0);
    reset = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_run();
    int b_sec, b_inc;
    b_sec = n_sec_en; b_inc = n_hour + n_min + n_clr;
    repeat (5) pulse_1hz();
    check("run_sec_en_pulses", n_sec_en - b_sec, 5);
    check("run_no_incre", n_hour + n_min + n_clr - b_inc, 0);
    check("run_mode", int'(mode), 0);
  endtask

  task automatic test_mode_bounce();
    int b_chg;
    b_chg = n_mode_chg;
    key_mode = 1'b1; step(); key_mode = 1'b0; repeat (2) step();
    key_mode = 1'b1; repeat (2) step(); key_mode = 1'b0; repeat (2) step();
    key_mode = 1'b1; step(); key_mode = 1'b0; repeat (6) step();
    check("bounce_rejected", int'(mode), 0);
    press_mode();
    check("bounce_mode_set_hour", int'(mode), 1);
    check("bounce_single_change", n_mode_chg - b_chg, 1);
  endtask

  task automatic test_set_hour();
    int b_hour, b_sec, b_min;
    pulse_2hz();
    check("blink_hour_on", int'(blank_hour), 1);
    check("blink_min_off", int'(blank_min), 0);
    pulse_2hz();
    check("blink_hour_off", int'(blank_hour), 0);
    b_hour = n_hour; b_sec = n_sec_en; b_min = n_min;
    pulse_1hz();
    repeat (3) press_inc();
    pulse_1hz();
    check("hour_incre_cycles", n_hour - b_hour, 3);
    check("hour_sec_en_paused", n_sec_en - b_sec, 0);
    check("hour_no_min_incre", n_min - b_min, 0);
    check("hour_mode_kept", int'(mode), 1);
  endtask

  task automatic test_auto_repeat();
    int b_min, b_hour;
    press_mode();
    check("repeat_mode_set_min", int'(mode), 2);
    b_min = n_min; b_hour = n_hour;
    key_inc = 1'b1; repeat (10) step();
    for (int k = 1; k <= 8; k++) begin
      pulse_2hz();
      if (k == 1) check("repeat_held_lit", int'(blank_min), 0);
      if (k == 2) check("repeat_before_start", n_min - b_min, 1);
      if (k == 3) check("repeat_first", n_min - b_min, 2);
    end
    key_inc = 1'b0; repeat (10) step();
    check("repeat_total_min", n_min - b_min, 7);
    check("repeat_no_hour", n_hour - b_hour, 0);
    pulse_2hz();
    check("repeat_stops_after_release", n_min - b_min, 7);
  endtask

  task automatic test_set_sec_timeout();
    int b_clr, b_sec, b_inc;
    press_mode();
    check("sec_mode_set_sec", int'(mode), 3);
    b_clr = n_clr; b_inc = n_hour + n_min; b_sec = n_sec_en;
    press_inc();
    check("sec_clr_one_cycle", n_clr - b_clr, 1);
    check("sec_no_incre", n_hour + n_min - b_inc, 0);
    repeat (9) pulse_1hz();
    check("timeout_not_yet", int'(mode), 3);
    pulse_1hz();
    check("timeout_to_run", int'(mode), 0);
    check("timeout_sec_en_paused", n_sec_en - b_sec, 0);
    pulse_1hz();
    check("timeout_run_resumes", n_sec_en - b_sec, 1);
  endtask

  task automatic test_both_keys_and_reset();
    int b_hour, b_min;
    press_mode();
    check("both_start_hour", int'(mode), 1);
    b_hour = n_hour; b_min = n_min;
    key_mode = 1'b1; key_inc = 1'b1; repeat (10) step();
    key_mode = 1'b0; key_inc = 1'b0; repeat (10) step();
    check("both_mode_wins", int'(mode), 2);
    check("both_no_hour_incre", n_hour - b_hour, 0);
    check("both_no_min_incre", n_min - b_min, 0);
    reset = 1'b0;
    #2;
    check("midreset_mode", int'(mode), 0);
    check("midreset_strobes", int'({sec_en, hour_incre, min_incre, sec_clr_n}), 1);
    step(); reset = 1'b1; repeat (3) step();
    check("after_reset_mode", int'(mode), 0);
    check("never_multi_strobe", n_multi, 0);
  endtask

  initial begin
    test_reset();
    test_run();
    test_mode_bounce();
    test_set_hour();
    test_auto_repeat();
    test_set_sec_timeout();
    test_both_keys_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
